// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_responder
// Purpose  : Far-end UART peer. Receives 8N1 frames on rxd, queues the bytes
//            in a small circular FIFO and retransmits each one on txd as 8N1.
//            Optional ASCII case swap of echoed letters when the macro
//            ECHO_CASE_SWAP_EN is defined (default build: verbatim echo).
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            rxd        - serial input, idle high, asynchronous to clk
//            tx_hold    - 1 = do not start a new TX frame
//            txd        - serial output, idle high
//            rx_byte    - last correctly received byte
//            rx_ok      - one-cycle pulse, rx_byte updated
//            frame_err  - one-cycle pulse, stop bit sampled low
//            ovf        - sticky, a received byte was dropped (FIFO full)
//            tx_busy    - TX frame in progress
//            fifo_cnt   - bytes held in the FIFO
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_responder #(
  parameter int F_CLK = 50_000_000,
  parameter int BAUD  = 38_400,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rxd,
  input  logic                     tx_hold,
  output logic                     txd,
  output logic [7:0]               rx_byte,
  output logic                     rx_ok,
  output logic                     frame_err,
  output logic                     ovf,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int NBIT  = F_CLK / BAUD;
  localparam int NHALF = NBIT / 2;
  localparam int CNT_W = $clog2(NBIT + 1);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(NBIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(NHALF - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // rxd synchronizer; rxs_prev is kept only for falling-edge detection
  // --------------------------------------------------------------------------
  logic rx_meta, rxs, rxs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_tick;
  logic             rx_half;

  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxs_prev && !rxs) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rxs ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rxs) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_sh     <= 8'h00;
      rx_byte   <= 8'h00;
      rx_ok     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ok     <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[7:1]};   // LSB arrives first
            rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_ok   <= 1'b1;
              rx_byte <= rx_sh;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_cnt <= '0;
          rx_bit <= 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO. The push is the registered rx_ok pulse carrying rx_byte, so the
  // write lands at the end of the rx_ok cycle. A pop in the same cycle frees
  // a slot first, letting a push into a full FIFO through.
  // --------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push_ok;
  logic          fifo_full;
  logic [7:0]    head;
  logic [7:0]    tx_byte;

  assign fifo_full = (count == FULL_CNT);
  assign push_ok   = rx_ok && (!fifo_full || pop);
  assign head      = mem[rd_ptr];
  assign fifo_cnt  = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (rx_ok && !push_ok) ovf <= 1'b1;
    end
  end

`ifdef ECHO_CASE_SWAP_EN
  // Letters A-Z / a-z differ only in bit 5
  assign tx_byte = (((head >= 8'h41) && (head <= 8'h5A)) ||
                    ((head >= 8'h61) && (head <= 8'h7A))) ? (head ^ 8'h20) : head;
`else
  assign tx_byte = head;
`endif

  // --------------------------------------------------------------------------
  // Transmitter. The last cycle of the stop bit doubles as the idle decision
  // point so back-to-back frames start with no idle gap; tx_hold and the FIFO
  // level are evaluated there exactly as they would be in IDLE.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [8:0]       tx_sh;   // remaining data bits followed by the stop bit
  logic             tx_tick;
  logic             can_start;

  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign can_start = (count != '0) && !tx_hold;
  assign tx_busy   = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          tx_next = TX_START;
        end
      end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP: begin
        if (tx_tick) begin
          if (can_start) begin
            pop     = 1'b1;
            tx_next = TX_START;
          end else begin
            tx_next = TX_IDLE;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd    <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= 3'd0;
      tx_sh  <= 9'h1FF;
    end else if (pop) begin
      txd    <= 1'b0;
      tx_sh  <= {1'b1, tx_byte};
      tx_cnt <= '0;
      tx_bit <= 3'd0;
    end else if (tx_state == TX_IDLE) begin
      txd    <= 1'b1;
      tx_cnt <= '0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      txd    <= tx_sh[0];
      tx_sh  <= {1'b1, tx_sh[8:1]};
      if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_echo_responder
// Purpose  : Self-checking bench for uart_echo_responder. A line-level TX
//            decoder and an rx_ok/frame_err monitor feed queues that are
//            compared against a byte-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_responder;

  localparam int F_CLK = 50_000_000;
  localparam int BAUD  = 1_562_500;
  localparam int DEPTH = 4;
  localparam int NBIT  = F_CLK / BAUD;   // 32
  localparam int NHALF = NBIT / 2;       // 16

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       tx_hold;
  logic       txd;
  logic [7:0] rx_byte;
  logic       rx_ok;
  logic       frame_err;
  logic       ovf;
  logic       tx_busy;
  logic [$clog2(DEPTH):0] fifo_cnt;

  uart_echo_responder #(.F_CLK(F_CLK), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .tx_hold   (tx_hold),
    .txd       (txd),
    .rx_byte   (rx_byte),
    .rx_ok     (rx_ok),
    .frame_err (frame_err),
    .ovf       (ovf),
    .tx_busy   (tx_busy),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         t;
  } ev_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rst_epoch = 0;
  int   ferr_cnt = 0;
  ev_t  tx_got[$];
  ev_t  rx_got[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int   starts[$];
  int   rxt[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected echo of a byte, straight from the echo rule
  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef ECHO_CASE_SWAP_EN
    if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A)))
      return b ^ 8'h20;
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      tick(NBIT);
    end
  endtask

  // rx_ok / frame_err monitor
  ev_t rx_ev;
  initial forever begin
    @(negedge clk);
    if (rx_ok === 1'b1) begin
      rx_ev.b = rx_byte;
      rx_ev.t = cyc;
      rx_got.push_back(rx_ev);
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  // txd line decoder: samples mid-bit, discards frames cut by a reset
  ev_t        tx_ev;
  int         mon_t0, mon_ep;
  logic [7:0] mon_b;
  logic       mon_st, mon_sb;
  initial forever begin
    do @(negedge clk); while (txd !== 1'b0);
    mon_t0 = cyc;
    mon_ep = rst_epoch;
    repeat (NHALF) @(negedge clk);
    mon_st = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (NBIT) @(negedge clk);
      mon_b[i] = txd;
    end
    repeat (NBIT) @(negedge clk);
    mon_sb = txd;
    if (mon_ep == rst_epoch) begin
      check("tx start bit", 32'(mon_st), 32'd0);
      check("tx stop bit", 32'(mon_sb), 32'd1);
      tx_ev.b = mon_b;
      tx_ev.t = mon_t0;
      tx_got.push_back(tx_ev);
    end
    repeat (NHALF - 1) @(negedge clk);
  end

  task automatic expect_all(input int n, input string tag);
    int         waited;
    ev_t        g;
    logic [7:0] e;
    waited = 0;
    while ((tx_got.size() < n) && (waited < (n + 1) * 12 * NBIT)) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " tx count"}, 32'(tx_got.size()), 32'(n));
    check({tag, " rx count"}, 32'(rx_got.size()), 32'(exp_rx.size()));
    starts.delete();
    rxt.delete();
    while ((tx_got.size() > 0) && (exp_tx.size() > 0)) begin
      g = tx_got.pop_front();
      e = exp_tx.pop_front();
      check({tag, " tx byte"}, 32'(g.b), 32'(e));
      starts.push_back(g.t);
    end
    while ((rx_got.size() > 0) && (exp_rx.size() > 0)) begin
      g = rx_got.pop_front();
      e = exp_rx.pop_front();
      check({tag, " rx_byte"}, 32'(g.b), 32'(e));
      rxt.push_back(g.t);
    end
    exp_tx.delete();
    exp_rx.delete();
    tx_got.delete();
    rx_got.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         f0;
    int         w;
    logic [7:0] b;

    rxd     = 1'b1;
    tx_hold = 1'b0;
    rst_n   = 1'b0;
    tick(5);
    @(negedge clk);
    check("reset txd", 32'(txd), 32'd1);
    check("reset rx_byte", 32'(rx_byte), 32'd0);
    check("reset rx_ok", 32'(rx_ok), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset fifo_cnt", 32'(fifo_cnt), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // Single byte echo and its latency from rx_ok
    send_frame(8'h41, 1'b1);
    exp_rx.push_back(8'h41);
    exp_tx.push_back(echo_of(8'h41));
    expect_all(1, "echo41");
    if ((starts.size() > 0) && (rxt.size() > 0))
      check("echo latency", 32'(starts[0]), 32'(rxt[0] + 2));

    // Short low glitch shorter than half a bit
    f0  = ferr_cnt;
    rxd = 1'b0;
    tick(NHALF / 2);
    rxd = 1'b1;
    tick(12 * NBIT);
    @(negedge clk);
    check("glitch rx_ok", 32'(rx_got.size()), 32'd0);
    check("glitch frame_err", 32'(ferr_cnt), 32'(f0));
    check("glitch tx frames", 32'(tx_got.size()), 32'd0);
    check("glitch txd", 32'(txd), 32'd1);

    // Framing error, held break, then recovery
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    tick(3 * NBIT);
    @(negedge clk);
    check("ferr pulse", 32'(ferr_cnt), 32'(f0 + 1));
    check("ferr no rx_ok", 32'(rx_got.size()), 32'd0);
    check("ferr fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("ferr tx_busy", 32'(tx_busy), 32'd0);
    rxd = 1'b1;
    tick(2 * NBIT);
    send_frame(8'h33, 1'b1);
    exp_rx.push_back(8'h33);
    exp_tx.push_back(echo_of(8'h33));
    expect_all(1, "after break");

    // tx_hold fills the FIFO, fifth byte overflows
    tx_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = 8'h10 + 8'(k);
      send_frame(b, 1'b1);
      exp_rx.push_back(b);
      if (k < DEPTH) exp_tx.push_back(echo_of(b));
    end
    tick(NBIT);
    @(negedge clk);
    check("hold fifo_cnt", 32'(fifo_cnt), 32'(DEPTH));
    check("hold ovf", 32'(ovf), 32'd1);
    check("hold tx_busy", 32'(tx_busy), 32'd0);
    check("hold no tx", 32'(tx_got.size()), 32'd0);
    tx_hold = 1'b0;
    expect_all(DEPTH, "held");
    for (int k = 1; k < starts.size(); k++)
      check("held gap", 32'(starts[k] - starts[k-1]), 32'(10 * NBIT));
    tick(NBIT);
    @(negedge clk);
    check("drained fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("ovf sticky", 32'(ovf), 32'd1);

    // Reset in the middle of a data bit of a TX frame
    b = 8'($urandom);
    b[3] = 1'b0;
    b[0] = 1'b1;
    send_frame(b, 1'b1);
    w = 0;
    while ((tx_busy !== 1'b1) && (w < 4 * NBIT)) begin
      tick(1);
      w++;
    end
    check("busy before reset", 32'(tx_busy), 32'd1);
    tick(4 * NBIT + NHALF);
    #2;
    check("txd low before reset", 32'(txd), 32'd0);
    rst_epoch++;
    rst_n = 1'b0;
    #1;
    check("async txd", 32'(txd), 32'd1);
    check("async tx_busy", 32'(tx_busy), 32'd0);
    check("async rx_byte", 32'(rx_byte), 32'd0);
    check("async ovf", 32'(ovf), 32'd0);
    check("async fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("async rx_ok", 32'(rx_ok), 32'd0);
    check("async frame_err", 32'(frame_err), 32'd0);
    exp_tx.delete();
    exp_rx.delete();
    tx_got.delete();
    rx_got.delete();
    tick(3);
    rst_n = 1'b1;
    tick(12 * NBIT);
    send_frame(8'h7E, 1'b1);
    exp_rx.push_back(8'h7E);
    exp_tx.push_back(echo_of(8'h7E));
    expect_all(1, "after reset");

    // Back-to-back receive while TX idle
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    exp_rx.push_back(8'hFF);
    exp_rx.push_back(8'h00);
    exp_tx.push_back(echo_of(8'hFF));
    exp_tx.push_back(echo_of(8'h00));
    expect_all(2, "b2b");
    if (starts.size() == 2)
      check("b2b gap", 32'(starts[1] - starts[0]), 32'(10 * NBIT));
    check("b2b ovf", 32'(ovf), 32'd0);

    // Random bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      exp_rx.push_back(b);
      exp_tx.push_back(echo_of(b));
      tick($urandom_range(1, NBIT));
    end
    expect_all(6, "random");
    tick(NBIT);
    @(negedge clk);
    check("random ovf", 32'(ovf), 32'd0);
    check("random fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("random txd idle", 32'(txd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
